// File: rtl/sum_accumulator_pkg.sv
// Shared types and helpers for the post-adder-tree accumulation stage.
package sum_accumulator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } acc_state_e;

    typedef struct packed {
        logic signed [63:0] min_val;
        logic signed [63:0] max_val;
    } sat_limit_t;

    // Two's-complement range of an out_width-bit signed result.
    function automatic sat_limit_t sat_limit(input int unsigned out_width);
        sat_limit_t lim;
        lim.max_val = (64'sd1 <<< (out_width - 32'd1)) - 64'sd1;
        lim.min_val = -lim.max_val - 64'sd1;
        return lim;
    endfunction

endpackage

// File: rtl/round_saturate.sv
// Combinational arithmetic right shift with round-half-up, then signed saturation.
module round_saturate
    import sum_accumulator_pkg::*;
#(
    parameter int AccWidth = 32,
    parameter int OutWidth = 16,
    localparam int ShiftWidth = $clog2(AccWidth)
) (
    input  logic signed [AccWidth-1:0]   acc,
    input  logic        [ShiftWidth-1:0] shift,
    output logic signed [OutWidth-1:0]   data,
    output logic                         sat
);

    localparam sat_limit_t Lim = sat_limit(OutWidth);
    localparam logic signed [63:0] MaxVal = Lim.max_val;
    localparam logic signed [63:0] MinVal = Lim.min_val;
    localparam logic [ShiftWidth-1:0] ShiftOne = {{(ShiftWidth-1){1'b0}}, 1'b1};
    localparam logic [AccWidth:0] BiasOne = {{AccWidth{1'b0}}, 1'b1};

    logic signed [AccWidth:0] acc_ext_s;
    logic signed [AccWidth:0] bias_s;
    logic signed [AccWidth:0] sum_s;
    logic signed [AccWidth:0] shifted_s;
    logic signed [63:0]       r_s;

    // One extra bit keeps the rounding bias from wrapping the most positive acc.
    always_comb begin
        acc_ext_s = {acc[AccWidth-1], acc};
        bias_s    = '0;
        if (shift != '0) begin
            bias_s = BiasOne << (shift - ShiftOne);
        end else begin
            bias_s = '0;
        end
        sum_s     = acc_ext_s + bias_s;
        shifted_s = sum_s >>> shift;
        r_s       = 64'(shifted_s);
        if (r_s > MaxVal) begin
            data = MaxVal[OutWidth-1:0];
            sat  = 1'b1;
        end else if (r_s < MinVal) begin
            data = MinVal[OutWidth-1:0];
            sat  = 1'b1;
        end else begin
            data = r_s[OutWidth-1:0];
            sat  = 1'b0;
        end
    end

endmodule

// File: rtl/sum_accumulator.sv
// Streaming signed accumulator: sums a programmable number of adder-tree results,
// then rounds, shifts and saturates the total for the next stage.
module sum_accumulator
    import sum_accumulator_pkg::*;
#(
    parameter int InWidth  = 20,
    parameter int AccWidth = 32,
    parameter int OutWidth = 16,
    parameter int MaxBeats = 256,
    localparam int CntWidth   = $clog2(MaxBeats),
    localparam int ShiftWidth = $clog2(AccWidth)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [CntWidth-1:0]        cfg_beats_i,
    input  logic [ShiftWidth-1:0]      cfg_shift_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic signed [InWidth-1:0]  in_data_i,
    input  logic                       in_last_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic signed [OutWidth-1:0] out_data_o,
    output logic                       out_sat_o,
    output logic                       out_ovf_o
);

    localparam logic [CntWidth-1:0] CntOne = {{(CntWidth-1){1'b0}}, 1'b1};

    acc_state_e                 state_r, state_s;
    logic signed [AccWidth-1:0] acc_r, acc_s;
    logic [CntWidth-1:0]        cnt_r, cnt_s;
    logic [CntWidth-1:0]        beats_r, beats_s;
    logic [ShiftWidth-1:0]      shift_r, shift_s;
    logic                       ovf_r, ovf_s;
    logic                       in_ready_r;
    logic                       out_valid_r;

    logic signed [AccWidth-1:0] in_ext_s;
    logic signed [AccWidth-1:0] sum_s;
    logic [CntWidth-1:0]        cnt_inc_s;
    logic                       wrap_s;
    logic                       in_fire_s;

    assign in_ext_s  = AccWidth'(in_data_i);
    assign sum_s     = acc_r + in_ext_s;
    assign cnt_inc_s = cnt_r + CntOne;
    // Signed overflow: operands agree in sign but the sum does not.
    assign wrap_s    = (acc_r[AccWidth-1] == in_ext_s[AccWidth-1]) &&
                       (sum_s[AccWidth-1] != acc_r[AccWidth-1]);
    assign in_fire_s = in_valid_i && in_ready_r;

    // Next-state, accumulator and configuration-latch logic.
    always_comb begin
        state_s = state_r;
        acc_s   = acc_r;
        cnt_s   = cnt_r;
        beats_s = beats_r;
        shift_s = shift_r;
        ovf_s   = ovf_r;
        case (state_r)
            IDLE: begin
                if (in_fire_s) begin
                    acc_s   = in_ext_s;
                    cnt_s   = '0;
                    beats_s = cfg_beats_i;
                    shift_s = cfg_shift_i;
                    ovf_s   = 1'b0;
                    if ((cfg_beats_i == '0) || in_last_i) begin
                        state_s = OUT;
                    end else begin
                        state_s = ACC;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            ACC: begin
                if (in_fire_s) begin
                    acc_s = sum_s;
                    ovf_s = ovf_r | wrap_s;
                    cnt_s = cnt_inc_s;
                    if ((cnt_inc_s == beats_r) || in_last_i) begin
                        state_s = OUT;
                    end else begin
                        state_s = ACC;
                    end
                end else begin
                    state_s = ACC;
                end
            end
            OUT: begin
                if (out_ready_i) begin
                    state_s = IDLE;
                end else begin
                    state_s = OUT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, datapath and handshake registers; ready/valid are registered from next state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r     <= IDLE;
            acc_r       <= '0;
            cnt_r       <= '0;
            beats_r     <= '0;
            shift_r     <= '0;
            ovf_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            acc_r       <= acc_s;
            cnt_r       <= cnt_s;
            beats_r     <= beats_s;
            shift_r     <= shift_s;
            ovf_r       <= ovf_s;
            in_ready_r  <= (state_s != OUT);
            out_valid_r <= (state_s == OUT);
        end
    end

    round_saturate #(
        .AccWidth (AccWidth),
        .OutWidth (OutWidth)
    ) u_round_saturate (
        .acc   (acc_r),
        .shift (shift_r),
        .data  (out_data_o),
        .sat   (out_sat_o)
    );

    assign in_ready_o  = in_ready_r;
    assign out_valid_o = out_valid_r;
    assign out_ovf_o   = ovf_r;

endmodule
